sched_16bit: RTL and testbench
==============================

SCHED_16BIT -- requirements
Module: sched_16bit

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4: digit width fed to the systolic array per cycle; must divide 16.
REQ-002 SHALL have parameter LAT, default 4: array pipeline latency in cycles from last digit to valid arr_res; must be >= 1.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  operand pair accepted when high together with in_valid.
REQ-007 SHALL have port a  input  [1:16]  operand A; bit 1 is MSB.
REQ-008 SHALL have port b  input  [1:16]  operand B; bit 1 is MSB.
REQ-009 SHALL have port arr_a  output  [1:16]  latched A, held full-width to the array.
REQ-010 SHALL have port arr_b_dig  output  [1:DIGIT_W]  current digit of B.
REQ-011 SHALL have port arr_start  output  1  first-digit marker.
REQ-012 SHALL have port arr_en  output  1  array clock-enable.
REQ-013 SHALL have port arr_res  input  [1:16]  array product.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  result consumer ready.
REQ-016 SHALL have port out_c  output  [1:16]  captured product.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement a four-state machine: IDLE, FEED, WAIT, DONE.
REQ-019 SHALL drive in_ready = 1 only in IDLE.
REQ-020 SHALL, on an edge with in_valid & in_ready, latch a into arr_a and b into an internal register, clear the digit counter, and enter FEED.
REQ-021 SHALL, in FEED, drive arr_en = 1 and present B digit i (i = 0..16/DIGIT_W-1, MSB-first, i.e. bits [1+i*DIGIT_W : (i+1)*DIGIT_W]) during the i-th FEED cycle.
REQ-022 SHALL drive arr_start = 1 only during FEED digit 0.
REQ-023 SHALL leave FEED for WAIT on the edge that consumes the last digit.
REQ-024 SHALL, in WAIT, hold arr_en = 1 and arr_b_dig = 0 for exactly LAT cycles.
REQ-025 SHALL, on the last WAIT edge, register arr_res into out_c and enter DONE.
REQ-026 SHALL, with defaults, raise out_valid on the 8th rising edge after the accepting edge, i.e. after 16/DIGIT_W + LAT edges.
REQ-027 SHALL, in DONE, hold out_valid = 1 and out_c stable; arr_en = 0 in DONE and IDLE.
REQ-028 SHALL return to IDLE on an edge with out_valid & out_ready; out_c retains its value and out_valid drops.
REQ-029 SHALL ignore in_valid in FEED, WAIT and DONE; no new operand is accepted in the DONE->IDLE cycle.
REQ-030 SHALL keep arr_a stable from acceptance until the next acceptance.
REQ-031 SHALL treat out_ready held high as a continuous handshake, so DONE lasts exactly one cycle.

Reset
REQ-032 SHALL, while rst = 0, force state IDLE, and drive arr_a, out_c, the internal B register and the counters to 0.
REQ-033 SHALL, while rst = 0, drive arr_b_dig, arr_start, arr_en, out_valid and busy to 0, and in_ready to 1.
REQ-034 SHALL, on reset asserted mid-FEED or mid-WAIT, abandon the operation without producing out_valid.

Configuration
REQ-035 SHALL support macro SCHED_OP_CNT_EN.
REQ-036 SHALL, when SCHED_OP_CNT_EN is defined, add output op_cnt [1:16]: reset 0, incremented on each out_valid & out_ready edge, wrapping 16'hFFFF -> 16'h0000.
REQ-037 SHALL, when SCHED_OP_CNT_EN is undefined, omit op_cnt and its register entirely; all other behaviour is identical.

Verification
REQ-038 SHALL cover single operation: a = 16'h0001, b = 16'hABCD, out_ready = 1 -> arr_b_dig sequence A, B, C, D with arr_start on A; out_valid for 1 cycle on the 8th edge; out_c = 16'hABCD.
REQ-039 SHALL cover backpressure: out_ready = 0 for 5 cycles after out_valid -> out_valid and out_c held, in_ready = 0 throughout; release -> IDLE on the next edge.
REQ-040 SHALL cover ignored input: in_valid held high with changing a/b during FEED/WAIT -> arr_a and the digit sequence unchanged; the next acceptance occurs only in IDLE.
REQ-041 SHALL cover reset mid-WAIT: rst low at cycle 6 -> all outputs per REQ-032/033 immediately; no out_valid after release.
REQ-042 SHALL cover a parameter sweep: DIGIT_W = 2, LAT = 3 -> 8 digits fed; out_valid on the 11th edge.
REQ-043 SHALL cover, with SCHED_OP_CNT_EN, a counter preloaded via 65535 operations (or forced) -> op_cnt wraps to 0 on the next completion.

Source files
------------

// File: rtl/sched_16bit.sv
// rtl/sched_16bit.sv - digit-serial operand scheduler feeding a 16-bit systolic multiplier array.
// Optional `define SCHED_OP_CNT_EN adds the op_cnt completion counter output.
module sched_16bit #(
  parameter int DIGIT_W = 4,
  parameter int LAT     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:16]      a,
  input  logic [1:16]      b,
  output logic [1:16]      arr_a,
  output logic [1:DIGIT_W] arr_b_dig,
  output logic             arr_start,
  output logic             arr_en,
  input  logic [1:16]      arr_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:16]      out_c,
`ifdef SCHED_OP_CNT_EN
  output logic [1:16]      op_cnt,
`endif
  output logic             busy
);

  localparam int NDIG   = 16 / DIGIT_W;
  localparam int CNT_MX = (NDIG > LAT) ? NDIG : LAT;
  localparam int CW     = $clog2(CNT_MX) + 1;
  localparam logic [CW-1:0] LAST_DIG  = CW'(NDIG - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:16]   b_reg;
  logic [15:0]   b_sh;
  logic          accept;
  logic          capture;

  // Shifting the current digit to the top keeps the MSB-first selection independent of range direction.
  always_comb begin
    b_sh = b_reg << (DIGIT_W * cnt);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    arr_en    = 1'b0;
    arr_start = 1'b0;
    arr_b_dig = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FEED;
        end
      end
      FEED: begin
        arr_en    = 1'b1;
        arr_start = (cnt == '0);
        arr_b_dig = b_sh[15 -: DIGIT_W];
        if (cnt == LAST_DIG) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT: begin
        arr_en = 1'b1;
        if (cnt == LAST_WAIT) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_a <= '0;
      b_reg <= '0;
    end else if (accept) begin
      arr_a <= a;
      b_reg <= b;
    end
  end

  // out_c keeps the last product after the handshake; only a new capture replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_c <= '0;
    end else if (capture) begin
      out_c <= arr_res;
    end
  end

`ifdef SCHED_OP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt <= '0;
    end else if (out_valid && out_ready) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sched_16bit.sv
// tb/tb_sched_16bit.sv - self-checking bench for sched_16bit (default and DIGIT_W=2/LAT=3 instances).
module tb_sched_16bit;

  localparam int DW  = 4;
  localparam int LT  = 4;
  localparam int ND  = 16 / DW;
  localparam int DW2 = 2;
  localparam int LT2 = 3;
  localparam int ND2 = 16 / DW2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:16] a = '0;
  logic [1:16] b = '0;
  logic [1:16] arr_a;
  logic [1:DW] arr_b_dig;
  logic        arr_start;
  logic        arr_en;
  logic [1:16] arr_res = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:16] out_c;
  logic        busy;

  logic         in_valid2 = 1'b0;
  logic         in_ready2;
  logic [1:16]  a2 = '0;
  logic [1:16]  b2 = '0;
  logic [1:16]  arr_a2;
  logic [1:DW2] arr_b_dig2;
  logic         arr_start2;
  logic         arr_en2;
  logic [1:16]  arr_res2 = '0;
  logic         out_valid2;
  logic         out_ready2 = 1'b1;
  logic [1:16]  out_c2;
  logic         busy2;

`ifdef SCHED_OP_CNT_EN
  logic [1:16] op_cnt;
  logic [1:16] op_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int ops    = 0;

  always #5 clk = ~clk;

  sched_16bit #(.DIGIT_W(DW), .LAT(LT)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .arr_a(arr_a), .arr_b_dig(arr_b_dig), .arr_start(arr_start),
    .arr_en(arr_en), .arr_res(arr_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c),
`ifdef SCHED_OP_CNT_EN
    .op_cnt(op_cnt),
`endif
    .busy(busy)
  );

  sched_16bit #(.DIGIT_W(DW2), .LAT(LT2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .arr_a(arr_a2), .arr_b_dig(arr_b_dig2), .arr_start(arr_start2),
    .arr_en(arr_en2), .arr_res(arr_res2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_c(out_c2),
`ifdef SCHED_OP_CNT_EN
    .op_cnt(op_cnt2),
`endif
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected digit i of v, MSB-first, for digit width w.
  function automatic logic [31:0] digit_of(input logic [15:0] v, input int i, input int w);
    return (32'(v) >> (16 - (i + 1) * w)) & ((32'd1 << w) - 1);
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int bp, input bit noisy);
    logic [15:0] exp_c;
    exp_c = av * bv;
    chk("idle_ready", in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = noisy;
    for (int i = 0; i < ND; i++) begin
      chk("feed_en", arr_en, 1);
      chk("feed_start", arr_start, (i == 0));
      chk("feed_dig", arr_b_dig, digit_of(bv, i, DW));
      chk("feed_a", arr_a, av);
      chk("feed_flags", {in_ready, busy, out_valid}, 3'b010);
      if (noisy) begin a = $urandom; b = $urandom; end
      arr_res = $urandom;
      step();
    end
    for (int w = 0; w < LT; w++) begin
      chk("wait_en", arr_en, 1);
      chk("wait_dig", {arr_start, arr_b_dig}, 0);
      chk("wait_flags", {in_ready, busy, out_valid}, 3'b010);
      chk("wait_a", arr_a, av);
      if (noisy) begin a = $urandom; b = $urandom; end
      arr_res = (w == LT - 1) ? exp_c : 16'($urandom);
      step();
    end
    chk("done_valid", out_valid, 1);
    chk("done_c", out_c, exp_c);
    chk("done_flags", {in_ready, busy, arr_en}, 3'b010);
    out_ready = (bp == 0);
    for (int k = 0; k < bp; k++) begin
      arr_res = $urandom;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_c", out_c, exp_c);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    ops++;
    chk("post_valid", out_valid, 0);
    chk("post_flags", {in_ready, busy, arr_en}, 3'b100);
    chk("post_c", out_c, exp_c);
    chk("post_a", arr_a, av);
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef SCHED_OP_CNT_EN
    chk("op_cnt", op_cnt, 32'(ops[15:0]));
`endif
  endtask

  initial begin
    logic [15:0] av, bv;
    bit seen;

    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_flags", {busy, arr_en, arr_start, out_valid}, 0);
    chk("rst_a", arr_a, 0);
    chk("rst_c", out_c, 0);
    chk("rst_dig", arr_b_dig, 0);
`ifdef SCHED_OP_CNT_EN
    chk("rst_op_cnt", op_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step();

    run_op(16'h0001, 16'hABCD, 0, 1'b0);
    run_op(16'($urandom), 16'($urandom), 5, 1'b0);
    run_op(16'($urandom), 16'($urandom), 0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset asserted while in WAIT: the operation must vanish.
    a = $urandom; b = $urandom; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("mid_wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mr_ready", in_ready, 1);
    chk("mr_flags", {busy, arr_en, arr_start, out_valid}, 0);
    chk("mr_a", arr_a, 0);
    chk("mr_c", out_c, 0);
    chk("mr_dig", arr_b_dig, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("mr_no_valid", seen, 0);
    ops = 0;
    run_op(16'($urandom), 16'($urandom), 1, 1'b0);

    // Narrow-digit instance: 8 digits, out_valid after 11 edges.
    av = $urandom; bv = $urandom;
    a2 = av; b2 = bv; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < ND2; i++) begin
      chk("p2_dig", arr_b_dig2, digit_of(bv, i, DW2));
      chk("p2_start", arr_start2, (i == 0));
      chk("p2_en", {arr_en2, out_valid2}, 2'b10);
      arr_res2 = $urandom;
      step();
    end
    for (int w = 0; w < LT2; w++) begin
      chk("p2_wait", {arr_en2, arr_b_dig2, out_valid2}, 4'b1000);
      arr_res2 = (w == LT2 - 1) ? av ^ bv : 16'($urandom);
      step();
    end
    chk("p2_valid", out_valid2, 1);
    chk("p2_c", out_c2, 32'(av ^ bv));
    step();
    chk("p2_idle", {out_valid2, in_ready2, busy2}, 3'b010);

`ifdef SCHED_OP_CNT_EN
    force u_dut.op_cnt = 16'hFFFF;
    #1;
    release u_dut.op_cnt;
    ops = 16'hFFFF;
    run_op(16'($urandom), 16'($urandom), 0, 1'b0);
    chk("op_cnt_wrap", op_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
